// File: rtl/axi_mmu_tagger.sv
// AXI tagger in front of the IOMMU: registers AW/AR, attaches stream/substream IDs, bounds
// outstanding traffic per direction and lets the identity change only once the pipe is drained.

// Minimal stand-in for the SoC AXI package so the block elaborates on its own.
package ariane_axi_soc;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic        user;
  } aw_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic        user;
    logic [23:0] stream_id;
    logic        ss_id_valid;
    logic [19:0] substream_id;
  } aw_chan_mmu_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic        user;
  } ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic        user;
    logic [23:0] stream_id;
    logic        ss_id_valid;
    logic [19:0] substream_id;
  } ar_chan_mmu_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        user;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic       user;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    aw_chan_mmu_t aw;
    logic         aw_valid;
    w_chan_t      w;
    logic         w_valid;
    logic         b_ready;
    ar_chan_mmu_t ar;
    logic         ar_valid;
    logic         r_ready;
  } req_mmu_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

module axi_mmu_tagger #(
  parameter int unsigned MaxTxns        = 8,
  parameter int unsigned DeviceIdWidth  = 24,
  parameter int unsigned ProcessIdWidth = 20,
  parameter type         slv_req_t      = ariane_axi_soc::req_t,
  parameter type         mst_req_t      = ariane_axi_soc::req_mmu_t,
  parameter type         rsp_t          = ariane_axi_soc::resp_t
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  slv_req_t                         slv_req_i,
  output rsp_t                             slv_rsp_o,
  output mst_req_t                         mst_req_o,
  input  rsp_t                             mst_rsp_i,
  input  logic [DeviceIdWidth-1:0]         cfg_did_i,
  input  logic                             cfg_pv_i,
  input  logic [ProcessIdWidth-1:0]        cfg_pid_i,
  input  logic                             cfg_update_i,
  output logic                             cfg_busy_o,
  output logic [$clog2(MaxTxns+1)-1:0]     wr_cnt_o,
  output logic [$clog2(MaxTxns+1)-1:0]     rd_cnt_o
);

  localparam int unsigned CntW = $clog2(MaxTxns + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxns);

  typedef enum logic [1:0] {StIdle, StDrain, StApply} state_e;

  state_e                    state_q, state_d;
  logic [DeviceIdWidth-1:0]  act_did_q, act_did_d, pend_did_q, pend_did_d;
  logic                      act_pv_q, act_pv_d, pend_pv_q, pend_pv_d;
  logic [ProcessIdWidth-1:0] act_pid_q, act_pid_d, pend_pid_q, pend_pid_d;
  logic [CntW-1:0]           wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  // Only the aw/ar halves of this register are real state; the rest is tied to zero.
  mst_req_t                  stg_q, stg_d;

  logic aw_rdy, ar_rdy, aw_hs, ar_hs, b_hs, rl_hs, drained, busy;

  always_comb begin
    aw_rdy  = (state_q == StIdle) && (wr_cnt_q != MaxCnt) &&
              (!stg_q.aw_valid || mst_rsp_i.aw_ready);
    ar_rdy  = (state_q == StIdle) && (rd_cnt_q != MaxCnt) &&
              (!stg_q.ar_valid || mst_rsp_i.ar_ready);
    aw_hs   = slv_req_i.aw_valid && aw_rdy;
    ar_hs   = slv_req_i.ar_valid && ar_rdy;
    b_hs    = mst_rsp_i.b_valid && slv_req_i.b_ready;
    rl_hs   = mst_rsp_i.r_valid && slv_req_i.r_ready && mst_rsp_i.r.last;
    drained = (wr_cnt_q == '0) && (rd_cnt_q == '0) && !stg_q.aw_valid && !stg_q.ar_valid;
  end

  always_comb begin
    stg_d         = stg_q;
    stg_d.w       = '0;
    stg_d.w_valid = 1'b0;
    stg_d.b_ready = 1'b0;
    stg_d.r_ready = 1'b0;
    if (stg_q.aw_valid && mst_rsp_i.aw_ready) stg_d.aw_valid = 1'b0;
    if (stg_q.ar_valid && mst_rsp_i.ar_ready) stg_d.ar_valid = 1'b0;
    if (aw_hs) begin
      stg_d.aw_valid        = 1'b1;
      stg_d.aw.id           = slv_req_i.aw.id;
      stg_d.aw.addr         = slv_req_i.aw.addr;
      stg_d.aw.len          = slv_req_i.aw.len;
      stg_d.aw.size         = slv_req_i.aw.size;
      stg_d.aw.burst        = slv_req_i.aw.burst;
      stg_d.aw.lock         = slv_req_i.aw.lock;
      stg_d.aw.cache        = slv_req_i.aw.cache;
      stg_d.aw.prot         = slv_req_i.aw.prot;
      stg_d.aw.qos          = slv_req_i.aw.qos;
      stg_d.aw.region       = slv_req_i.aw.region;
      stg_d.aw.atop         = slv_req_i.aw.atop;
      stg_d.aw.user         = slv_req_i.aw.user;
      stg_d.aw.stream_id    = act_did_q;
      stg_d.aw.ss_id_valid  = act_pv_q;
      stg_d.aw.substream_id = act_pv_q ? act_pid_q : '0;
    end
    if (ar_hs) begin
      stg_d.ar_valid        = 1'b1;
      stg_d.ar.id           = slv_req_i.ar.id;
      stg_d.ar.addr         = slv_req_i.ar.addr;
      stg_d.ar.len          = slv_req_i.ar.len;
      stg_d.ar.size         = slv_req_i.ar.size;
      stg_d.ar.burst        = slv_req_i.ar.burst;
      stg_d.ar.lock         = slv_req_i.ar.lock;
      stg_d.ar.cache        = slv_req_i.ar.cache;
      stg_d.ar.prot         = slv_req_i.ar.prot;
      stg_d.ar.qos          = slv_req_i.ar.qos;
      stg_d.ar.region       = slv_req_i.ar.region;
      stg_d.ar.user         = slv_req_i.ar.user;
      stg_d.ar.stream_id    = act_did_q;
      stg_d.ar.ss_id_valid  = act_pv_q;
      stg_d.ar.substream_id = act_pv_q ? act_pid_q : '0;
    end
  end

  // Decrement at zero saturates; the assertion below reports it.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (aw_hs && !b_hs) wr_cnt_d = wr_cnt_q + 1'b1;
    else if (!aw_hs && b_hs && (wr_cnt_q != '0)) wr_cnt_d = wr_cnt_q - 1'b1;
    if (ar_hs && !rl_hs) rd_cnt_d = rd_cnt_q + 1'b1;
    else if (!ar_hs && rl_hs && (rd_cnt_q != '0)) rd_cnt_d = rd_cnt_q - 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    act_did_d  = act_did_q;
    act_pv_d   = act_pv_q;
    act_pid_d  = act_pid_q;
    pend_did_d = pend_did_q;
    pend_pv_d  = pend_pv_q;
    pend_pid_d = pend_pid_q;
    busy       = 1'b0;
    if (cfg_update_i) begin
      pend_did_d = cfg_did_i;
      pend_pv_d  = cfg_pv_i;
      pend_pid_d = cfg_pid_i;
    end
    case (state_q)
      StIdle: begin
        if (cfg_update_i) state_d = StDrain;
      end
      StDrain: begin
        busy = 1'b1;
        if (drained) state_d = StApply;
      end
      StApply: begin
        busy      = 1'b1;
        act_did_d = pend_did_q;
        act_pv_d  = pend_pv_q;
        act_pid_d = pend_pid_q;
        state_d   = cfg_update_i ? StDrain : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      act_did_q  <= '0;
      act_pv_q   <= 1'b0;
      act_pid_q  <= '0;
      pend_did_q <= '0;
      pend_pv_q  <= 1'b0;
      pend_pid_q <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      stg_q      <= '0;
    end else begin
      state_q    <= state_d;
      act_did_q  <= act_did_d;
      act_pv_q   <= act_pv_d;
      act_pid_q  <= act_pid_d;
      pend_did_q <= pend_did_d;
      pend_pv_q  <= pend_pv_d;
      pend_pid_q <= pend_pid_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      stg_q      <= stg_d;
    end
  end

  always_comb begin
    mst_req_o          = stg_q;
    mst_req_o.w        = slv_req_i.w;
    mst_req_o.w_valid  = slv_req_i.w_valid;
    mst_req_o.b_ready  = slv_req_i.b_ready;
    mst_req_o.r_ready  = slv_req_i.r_ready;
    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.aw_ready = aw_rdy;
    slv_rsp_o.ar_ready = ar_rdy;
    cfg_busy_o         = busy;
    wr_cnt_o           = wr_cnt_q;
    rd_cnt_o           = rd_cnt_q;
  end

`ifndef SYNTHESIS
  a_no_b_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(b_hs && (wr_cnt_q == '0))) else $error("B response with no write outstanding");
  a_no_r_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rl_hs && (rd_cnt_q == '0))) else $error("last R beat with no read outstanding");
`endif

endmodule

// File: tb/tb_axi_mmu_tagger.sv
// Directed bench for axi_mmu_tagger: tagging, counters, limit, drain/switch and reset.
module tb_axi_mmu_tagger;
  import ariane_axi_soc::*;

  logic        clk = 1'b0;
  logic        rst;
  req_t        slv_req;
  resp_t       slv_rsp;
  req_mmu_t    mst_req;
  resp_t       mst_rsp;
  logic [23:0] cfg_did;
  logic        cfg_pv;
  logic [19:0] cfg_pid;
  logic        cfg_update;
  logic        cfg_busy;
  logic [3:0]  wr_cnt, rd_cnt;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  axi_mmu_tagger #(
    .MaxTxns       (8),
    .DeviceIdWidth (24),
    .ProcessIdWidth(20),
    .slv_req_t     (req_t),
    .mst_req_t     (req_mmu_t),
    .rsp_t         (resp_t)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .slv_req_i   (slv_req),
    .slv_rsp_o   (slv_rsp),
    .mst_req_o   (mst_req),
    .mst_rsp_i   (mst_rsp),
    .cfg_did_i   (cfg_did),
    .cfg_pv_i    (cfg_pv),
    .cfg_pid_i   (cfg_pid),
    .cfg_update_i(cfg_update),
    .cfg_busy_o  (cfg_busy),
    .wr_cnt_o    (wr_cnt),
    .rd_cnt_o    (rd_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_cfg(input logic [23:0] did, input logic pv, input logic [19:0] pid);
    cfg_did    = did;
    cfg_pv     = pv;
    cfg_pid    = pid;
    cfg_update = 1'b1;
    cyc();
    cfg_update = 1'b0;
  endtask

  initial begin
    slv_req    = '0;
    mst_rsp    = '0;
    cfg_did    = '0;
    cfg_pv     = 1'b0;
    cfg_pid    = '0;
    cfg_update = 1'b0;
    rst        = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    check_eq("rst_aw_valid", mst_req.aw_valid, 0);
    check_eq("rst_ar_valid", mst_req.ar_valid, 0);
    check_eq("rst_busy", cfg_busy, 0);
    check_eq("rst_wr_cnt", wr_cnt, 0);
    check_eq("rst_rd_cnt", rd_cnt, 0);
    mst_rsp.b_valid = 1'b1;
    #1;
    check_eq("b_valid_pass", slv_rsp.b_valid, 1);
    mst_rsp.b_valid = 1'b0;
    cyc();

    // Load identity 0x12345 / 0xABC with nothing in flight.
    pulse_cfg(24'h12345, 1'b1, 20'hABC);
    check_eq("cfg_busy_rise", cfg_busy, 1);
    cyc();
    check_eq("cfg_busy_apply", cfg_busy, 1);
    cyc();
    check_eq("cfg_busy_fall", cfg_busy, 0);

    // Four back-to-back AWs, each visible downstream one cycle after acceptance.
    mst_rsp.aw_ready = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = 64'h1000 + 64'(k);
        slv_req.aw.id    = 4'(k);
      end else begin
        slv_req.aw_valid = 1'b0;
      end
      #1;
      if (k < 4) check_eq("b2b_aw_ready", slv_rsp.aw_ready, 1);
      if (k > 0) begin
        check_eq("b2b_aw_valid", mst_req.aw_valid, 1);
        check_eq("b2b_aw_addr", mst_req.aw.addr, 64'h1000 + 64'(k - 1));
        check_eq("b2b_stream_id", mst_req.aw.stream_id, 24'h12345);
        check_eq("b2b_ss_id_valid", mst_req.aw.ss_id_valid, 1);
        check_eq("b2b_substream_id", mst_req.aw.substream_id, 20'hABC);
      end
      cyc();
    end
    check_eq("b2b_wr_cnt4", wr_cnt, 4);
    check_eq("b2b_aw_idle", mst_req.aw_valid, 0);
    slv_req.b_ready = 1'b1;
    mst_rsp.b_valid = 1'b1;
    repeat (4) cyc();
    mst_rsp.b_valid = 1'b0;
    check_eq("b2b_wr_cnt0", wr_cnt, 0);

    // Three reads outstanding, then two update pulses while draining.
    mst_rsp.ar_ready = 1'b1;
    slv_req.r_ready  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      slv_req.ar_valid = 1'b1;
      slv_req.ar.addr  = 64'h2000 + 64'(k);
      cyc();
    end
    slv_req.ar_valid = 1'b0;
    check_eq("rd_cnt3", rd_cnt, 3);
    check_eq("ar_addr_last", mst_req.ar.addr, 64'h2002);
    check_eq("ar_stream_old", mst_req.ar.stream_id, 24'h12345);
    pulse_cfg(24'h3, 1'b1, 20'h55);
    slv_req.ar_valid = 1'b1;
    slv_req.ar.addr  = 64'hB000;
    slv_req.w_valid  = 1'b1;
    mst_rsp.w_ready  = 1'b1;
    #1;
    check_eq("drain_busy", cfg_busy, 1);
    check_eq("drain_ar_ready", slv_rsp.ar_ready, 0);
    check_eq("drain_w_valid", mst_req.w_valid, 1);
    check_eq("drain_w_ready", slv_rsp.w_ready, 1);
    pulse_cfg(24'h7, 1'b0, 20'hFF);
    for (int k = 0; k < 4; k++) begin
      mst_rsp.r_valid = 1'b1;
      mst_rsp.r.last  = (k > 0);
      #1;
      check_eq("drain_ar_gated", slv_rsp.ar_ready, 0);
      check_eq("drain_busy_r", cfg_busy, 1);
      cyc();
    end
    mst_rsp.r_valid = 1'b0;
    slv_req.w_valid = 1'b0;
    check_eq("drain_rd_cnt0", rd_cnt, 0);
    check_eq("drain_busy_last", cfg_busy, 1);
    cyc();
    check_eq("apply_busy", cfg_busy, 1);
    check_eq("apply_ar_ready", slv_rsp.ar_ready, 0);
    cyc();
    check_eq("switch_busy_fall", cfg_busy, 0);
    check_eq("switch_ar_ready", slv_rsp.ar_ready, 1);
    cyc();
    slv_req.ar_valid = 1'b0;
    check_eq("new_ar_valid", mst_req.ar_valid, 1);
    check_eq("new_ar_addr", mst_req.ar.addr, 64'hB000);
    check_eq("new_stream_id", mst_req.ar.stream_id, 24'h7);
    check_eq("pv_mask_ss_valid", mst_req.ar.ss_id_valid, 0);
    check_eq("pv_mask_substream", mst_req.ar.substream_id, 0);
    check_eq("new_rd_cnt1", rd_cnt, 1);
    mst_rsp.r_valid = 1'b1;
    mst_rsp.r.last  = 1'b1;
    cyc();
    mst_rsp.r_valid = 1'b0;
    check_eq("new_rd_cnt0", rd_cnt, 0);

    // Write limit: eight accepted, ninth waits for a freed slot.
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = 64'h3000;
    for (int k = 0; k < 8; k++) begin
      #1;
      check_eq("lim_aw_ready", slv_rsp.aw_ready, 1);
      cyc();
    end
    check_eq("lim_wr_cnt8", wr_cnt, 8);
    check_eq("lim_aw_blocked", slv_rsp.aw_ready, 0);
    check_eq("lim_aw_ss_valid", mst_req.aw.ss_id_valid, 0);
    check_eq("lim_aw_substream", mst_req.aw.substream_id, 0);
    cyc();
    check_eq("lim_wr_cnt8_hold", wr_cnt, 8);
    mst_rsp.b_valid = 1'b1;
    #1;
    check_eq("lim_no_bypass", slv_rsp.aw_ready, 0);
    cyc();
    mst_rsp.b_valid = 1'b0;
    #1;
    check_eq("lim_wr_cnt7", wr_cnt, 7);
    check_eq("lim_ninth_ready", slv_rsp.aw_ready, 1);
    cyc();
    slv_req.aw_valid = 1'b0;
    check_eq("lim_wr_cnt8_again", wr_cnt, 8);
    mst_rsp.b_valid = 1'b1;
    repeat (3) cyc();
    mst_rsp.b_valid = 1'b0;
    check_eq("sim_wr_cnt5", wr_cnt, 5);
    slv_req.aw_valid = 1'b1;
    mst_rsp.b_valid  = 1'b1;
    cyc();
    slv_req.aw_valid = 1'b0;
    mst_rsp.b_valid  = 1'b0;
    check_eq("sim_inc_dec", wr_cnt, 5);
    mst_rsp.b_valid = 1'b1;
    repeat (5) cyc();
    mst_rsp.b_valid = 1'b0;
    check_eq("sim_wr_cnt0", wr_cnt, 0);

    // Reset with a stalled AR staged and three reads counted.
    mst_rsp.ar_ready = 1'b1;
    slv_req.ar_valid = 1'b1;
    slv_req.ar.addr  = 64'h4000;
    repeat (3) cyc();
    slv_req.ar_valid = 1'b0;
    mst_rsp.ar_ready = 1'b0;
    check_eq("mid_rd_cnt3", rd_cnt, 3);
    cyc();
    check_eq("mid_ar_hold", mst_req.ar_valid, 1);
    check_eq("mid_ar_addr_hold", mst_req.ar.addr, 64'h4000);
    pulse_cfg(24'h5, 1'b1, 20'h1);
    check_eq("mid_busy", cfg_busy, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_eq("rst2_ar_valid", mst_req.ar_valid, 0);
    check_eq("rst2_rd_cnt", rd_cnt, 0);
    check_eq("rst2_wr_cnt", wr_cnt, 0);
    check_eq("rst2_busy", cfg_busy, 0);
    mst_rsp.ar_ready = 1'b1;
    slv_req.ar_valid = 1'b1;
    slv_req.ar.addr  = 64'h5000;
    cyc();
    slv_req.ar_valid = 1'b0;
    check_eq("rst2_stream_id", mst_req.ar.stream_id, 0);
    check_eq("rst2_ss_valid", mst_req.ar.ss_id_valid, 0);
    check_eq("rst2_rd_cnt1", rd_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
